// File: rtl/ram_dp_be.sv
// ram_dp_be: simple-dual-port synchronous RAM.
// One write port with per-lane byte enables and one independent read port.
// Read data is registered, one cycle of latency, and qualified by rdValid.
// A clear sequencer zeroes the whole array after reset when CLEAR_ON_RESET=1.
// Optional build macro RAM_DP_BYPASS_EN: on a same-cycle, same-address read
// and write, the read returns the merged (write-first) word instead of the
// pre-write contents.
//
// Handshake: requests are single-cycle strobes (wrEnable / rdEnable) that are
// accepted on a rising edge only while busy=0. A read accepted at edge N
// presents its data on dataOut with rdValid=1 after edge N. rdValid is high for
// exactly one cycle per accepted read. There is no back-pressure.
module ram_dp_be #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NLANES        = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEnable,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [NLANES-1:0]     wrByteEn,
    input  logic                  rdEnable,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  rdValid,
    output logic                  busy,
    output logic                  dbgState
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clrAddr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rdWord;

    // State register: reset lands in CLEAR or READY depending on configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) state <= S_CLEAR;
            else                     state <= S_READY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR once the last address has been swept.
    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: if (clrAddr == LAST_ADDR) state_next = S_READY;
            S_READY: state_next = S_READY;
            default: state_next = S_READY;
        endcase
    end

    // Outputs of the FSM: busy for the whole sweep, state exposed for debug.
    always_comb begin
        busy     = (state == S_CLEAR);
        dbgState = state;
    end

    // Sweep pointer: restarts at 0 on every reset, advances once per clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrAddr <= '0;
        end else if (state == S_CLEAR) begin
            clrAddr <= clrAddr + 1'b1;
        end
    end

    // Array write: clear sweep has priority; user writes honour byte enables.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clrAddr] <= '0;
        end else if (wrEnable) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wrByteEn[i]) begin
                    mem[wrAddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wrData[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word selection: array contents, optionally merged with a colliding write.
    always_comb begin
        rdWord = mem[rdAddr];
`ifdef RAM_DP_BYPASS_EN
        if (wrEnable && (wrAddr == rdAddr)) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wrByteEn[i]) begin
                    rdWord[i*BYTE_WIDTH +: BYTE_WIDTH] = wrData[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

    // Read register: cleared on reset, forced quiet while busy, holds data when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut <= '0;
            rdValid <= 1'b0;
        end else if (busy) begin
            dataOut <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdEnable;
            if (rdEnable) dataOut <= rdWord;
        end
    end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be (ADDR_WIDTH=4). Expected read data is pushed
// into exp_q when a read is issued; a monitor pops and compares whenever the
// DUT raises rdValid.
module tb_ram_dp_be;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NL = 4;

    logic          clk;
    logic          rst;
    logic          wrEnable;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic [NL-1:0] wrByteEn;
    logic          rdEnable;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] dataOut;
    logic          rdValid;
    logic          busy;
    logic          dbg_state;

    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    ram_dp_be #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BYTE_WIDTH(8),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wrEnable(wrEnable),
        .wrAddr(wrAddr),
        .wrData(wrData),
        .wrByteEn(wrByteEn),
        .rdEnable(rdEnable),
        .rdAddr(rdAddr),
        .dataOut(dataOut),
        .rdValid(rdValid),
        .busy(busy),
        .dbgState(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && rdValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdValid: got data %h with no read outstanding", dataOut);
            end else begin
                check("read_data", dataOut, exp_q.pop_front());
            end
        end
    end

    // driver tasks: each starts just after a rising edge and ends just after the next
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
        wrEnable = 1'b1;
        wrAddr   = a;
        wrData   = d;
        wrByteEn = be;
        tick();
        wrEnable = 1'b0;
        wrByteEn = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rdEnable = 1'b1;
        rdAddr   = a;
        exp_q.push_back(e);
        tick();
        rdEnable = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    int            n;
    logic [DW-1:0] same_exp;

    initial begin
        rst      = 1'b1;
        wrEnable = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        wrByteEn = '0;
        rdEnable = 1'b0;
        rdAddr   = '0;

        // 1: reset state and clear sweep with rdEnable held
        repeat (2) tick();
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_rdValid", {31'd0, rdValid}, 32'd0);
        check("reset_dataOut", dataOut, 32'd0);
        rst      = 1'b0;
        rdEnable = 1'b1;
        rdAddr   = 4'd3;
        wait_clear(n);
        rdEnable = 1'b0;
        check("clear_cycles", n, 32'd16);
        check("clear_dataOut", dataOut, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rdEnable = 1'b1;
            rdAddr   = AW'(i);
            exp_q.push_back(32'd0);
            tick();
        end
        rdEnable = 1'b0;

        // 2: byte-enable merge
        wr(4'd3, 32'hDEADBEEF, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hDE22BE44);
        tick();
        check("single_rdValid_drop", {31'd0, rdValid}, 32'd0);

        // 3: streaming writes then back-to-back reads
        for (int i = 0; i < 16; i++) wr(AW'(i), i * 32'h01010101, 4'b1111);
        for (int i = 0; i < 16; i++) begin
            rdEnable = 1'b1;
            rdAddr   = AW'(i);
            exp_q.push_back(i * 32'h01010101);
            tick();
        end
        rdEnable = 1'b0;
        repeat (3) tick();
        check("hold_dataOut", dataOut, 32'h0F0F0F0F);
        check("idle_rdValid", {31'd0, rdValid}, 32'd0);

        // 4: same-cycle same-address read and write
        wr(4'd5, 32'hAAAAAAAA, 4'b1111);
`ifdef RAM_DP_BYPASS_EN
        same_exp = 32'h55555555;
`else
        same_exp = 32'hAAAAAAAA;
`endif
        wrEnable = 1'b1;
        wrAddr   = 4'd5;
        wrData   = 32'h55555555;
        wrByteEn = 4'b1111;
        rdEnable = 1'b1;
        rdAddr   = 4'd5;
        exp_q.push_back(same_exp);
        tick();
        wrEnable = 1'b0;
        wrByteEn = '0;
        rdEnable = 1'b0;
        rd(4'd5, 32'h55555555);
        // independent read and write to different addresses
        wrEnable = 1'b1;
        wrAddr   = 4'd6;
        wrData   = 32'h01234567;
        wrByteEn = 4'b1111;
        rdEnable = 1'b1;
        rdAddr   = 4'd7;
        exp_q.push_back(32'h07070707);
        tick();
        wrEnable = 1'b0;
        wrByteEn = '0;
        rdEnable = 1'b0;
        rd(4'd6, 32'h01234567);

        // 5: reset mid-clear
        wr(4'd2, 32'h12345678, 4'b1111);
        rd(4'd2, 32'h12345678);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_dataOut", dataOut, 32'd0);
        check("async_rst_rdValid", {31'd0, rdValid}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_clear_rst_busy", {31'd0, busy}, 32'd1);
        tick();
        rst = 1'b0;

        // 6: write during clear is ignored
        wrEnable = 1'b1;
        wrAddr   = 4'd9;
        wrData   = 32'hCAFEF00D;
        wrByteEn = 4'b1111;
        wait_clear(n);
        wrEnable = 1'b0;
        wrByteEn = '0;
        check("restart_clear_cycles", n, 32'd16);
        rd(4'd2, 32'd0);
        rd(4'd9, 32'd0);
        rd(4'd3, 32'd0);
        rd(4'd15, 32'd0);

        repeat (3) tick();
        check("outstanding_reads", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
Parametrised simple-dual-port synchronous RAM; successor to the single-port 32-bit word RAM used as program/data store in the project datapath.
- One write port with byte enables and one independent read port, both active in the same cycle.
- Registered read data with a valid flag.
- Hardware clear sequencer: the array is zeroed after reset; no init file is required.

Parameters:
ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per byte-enable lane; NLANES = DATA_WIDTH/BYTE_WIDTH
CLEAR_ON_RESET, 1, 1: zero the whole array after every reset; 0: contents undefined, ready immediately

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
wrEnable  input  1  write request this cycle
wrAddr  input  ADDR_WIDTH  write address
wrData  input  DATA_WIDTH  write data
wrByteEn  input  NLANES  per-lane write enable; lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
rdEnable  input  1  read request this cycle
rdAddr  input  ADDR_WIDTH  read address
dataOut  output  DATA_WIDTH  registered read data
rdValid  output  1  dataOut updated by a read accepted the previous cycle
busy  output  1  clear sequence in progress; requests ignored

Behaviour:
- Reset (async assert) sets the following:
  - dataOut=0, rdValid=0.
  - busy=1 and clrAddr=0 if CLEAR_ON_RESET=1, else busy=0.
  - FSM goes to CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0).
  - Array contents are not touched asynchronously.
- FSM states are CLEAR and READY.
  - CLEAR: each cycle writes all-zero to memory[clrAddr] and increments clrAddr.
  - When clrAddr = 2**ADDR_WIDTH-1 is written, the next state is READY; busy falls on that same edge.
  - Total clear time is exactly 2**ADDR_WIDTH cycles after reset release.
  - READY: stays in READY until the next reset.
- While busy=1: wrEnable and rdEnable are ignored, rdValid stays 0, and dataOut holds 0.
- Reset asserted mid-clear restarts the sweep at address 0.
- Write (READY, wrEnable=1):
  - On the rising edge, each lane with wrByteEn[i]=1 takes wrData lane i; other lanes keep their old value.
  - wrByteEn all-zero means no change.
- Read (READY, rdEnable=1) at edge N: dataOut=memory[rdAddr] and rdValid=1 after edge N (latency 1).
- With rdEnable=0, rdValid=0 on the next edge and dataOut holds its last value.
- Back-to-back reads every cycle give full throughput; rdValid stays high continuously.
- Read and write to different addresses in the same cycle are fully independent.
- Read and write to the same address in the same cycle: dataOut returns the pre-write contents (read-before-write), unless the optional feature is enabled.
- Addresses are used modulo depth; there are no out-of-range cases.
- All array writes use nonblocking assignment, so the same-edge read/write result does not depend on simulation ordering.

Optional Feature:
- Macro RAM_DP_BYPASS_EN.
- Defined: on a same-cycle same-address read and write in READY, dataOut is the merged word.
  - Enabled lanes take wrData; other lanes take the old memory lanes.
  - This is write-first forwarding; rdValid is unchanged.
- Undefined: read-before-write as above; no forwarding logic is synthesised.

Test Plan:
1. ADDR_WIDTH=4, CLEAR_ON_RESET=1, pulse rst, then hold rdEnable=1:
   - busy stays high exactly 16 cycles after release, rdValid=0 throughout.
   - After busy falls, reads of addresses 0..15 all return 0x00000000.
2. Write addr 3 with 0xDEADBEEF, wrByteEn=4'b1111, then write 0x11223344 with wrByteEn=4'b0101 → read addr 3 returns 0xDE22BE44 one cycle after rdEnable, with rdValid=1 for that one cycle.
3. Streaming: write addrs 0..15 with value addr*0x01010101, then read 0..15 on consecutive cycles → rdValid high for 16 consecutive cycles with the matching data; after rdEnable drops, dataOut holds 0x0F0F0F0F.
4. Addr 5 holds 0xAAAAAAAA; same cycle write 0x55555555 (all lanes) and read addr 5:
   - Without the macro, dataOut=0xAAAAAAAA; with RAM_DP_BYPASS_EN, dataOut=0x55555555.
   - A follow-up read returns 0x55555555 in both builds.
5. Assert rst during cycle 7 of the clear sweep, after writing 0x12345678 to addr 2 before the first reset:
   - busy restarts and lasts 16 cycles from the new release.
   - Addr 2 reads 0; dataOut and rdValid are 0 asynchronously while rst is high.
6. While busy=1, issue wrEnable to addr 9 with 0xCAFEF00D → ignored; after clear, addr 9 reads 0x00000000.
